// File: rtl/alu_pkg.sv
// Opcode map and iterative-unit state encoding shared by the sequential ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHRA = 5'd7;
  localparam logic [4:0] OP_ROR  = 5'd8;
  localparam logic [4:0] OP_ROL  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Signed multiply / restoring divide on operand magnitudes, one bit per cycle; fin is
// raised WIDTH+1 edges after go, and go is ignored while busy (no queuing).
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             fin
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opd;
  logic               sgn_lo;
  logic               sgn_hi;
  logic               mode_div;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;

  // Magnitude of MIN is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  assign mag_a   = a[WIDTH-1] ? -a : a;
  assign mag_b   = b[WIDTH-1] ? -b : b;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opd};
  assign prod    = {acc_hi, acc_lo};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opd      <= '0;
      sgn_lo   <= 1'b0;
      sgn_hi   <= 1'b0;
      mode_div <= 1'b0;
      busy     <= 1'b0;
      fin      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state    <= is_div ? DIV : MUL;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= is_div ? mag_a : mag_b;
            opd      <= is_div ? mag_b : mag_a;
            sgn_lo   <= a[WIDTH-1] ^ b[WIDTH-1];
            sgn_hi   <= is_div ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
            mode_div <= is_div;
            busy     <= 1'b1;
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
            fin   <= 1'b1;
          end
        end
        DIV: begin
          // Remainder is always below the divisor, so WIDTH bits hold the difference.
          acc_hi <= div_ge ? (div_sh[WIDTH-1:0] - opd) : div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
            fin   <= 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          fin   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          fin   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (mode_div) begin
      res_lo = sgn_lo ? -acc_lo : acc_lo;
      res_hi = sgn_hi ? -acc_hi : acc_hi;
    end else begin
      {res_hi, res_lo} = sgn_lo ? -prod : prod;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: logic/shift/add ops and zero-divisor DIV finish on the start edge, MUL/DIV
// finish WIDTH+1 edges later; start is dropped while busy and C/flags hold until the next done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               zero,
  output logic               neg,
  output logic               carry,
  output logic               ovf,
  output logic               dz,
  output logic               err
);

  localparam int SHW = $clog2(WIDTH);

  logic               accept;
  logic               is_md;
  logic               go;
  logic               md_div;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   lo_n;
  logic [WIDTH-1:0]   hi_n;
  logic               carry_n;
  logic               ovf_n;
  logic               dz_n;
  logic               err_n;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               fin;

  assign accept = start & ~busy;
  assign go     = accept & is_md;
  assign sh     = B[SHW-1:0];

  always_comb begin
    lo_n    = '0;
    hi_n    = '0;
    carry_n = 1'b0;
    ovf_n   = 1'b0;
    dz_n    = 1'b0;
    err_n   = 1'b0;
    is_md   = 1'b0;
    sum     = '0;
    rot     = '0;
    case (opcode)
      OP_ADD: begin
        sum     = {1'b0, A} + {1'b0, B};
        lo_n    = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
        ovf_n   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the inverted borrow.
        sum     = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        lo_n    = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
        ovf_n   = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: is_md = 1'b1;
      OP_DIV: begin
        if (B == '0) begin
          lo_n = '1;
          hi_n = A;
          dz_n = 1'b1;
        end else begin
          is_md = 1'b1;
        end
      end
      OP_SHR:  lo_n = A >> sh;
      OP_SHL:  lo_n = A << sh;
      OP_SHRA: lo_n = $unsigned($signed(A) >>> sh);
      OP_ROR: begin
        rot  = {A, A} >> sh;
        lo_n = rot[WIDTH-1:0];
      end
      OP_ROL: begin
        rot  = {A, A} << sh;
        lo_n = rot[2*WIDTH-1:WIDTH];
      end
      OP_AND:  lo_n = A & B;
      OP_OR:   lo_n = A | B;
      OP_NEG:  lo_n = -A;
      OP_NOT:  lo_n = ~A;
      default: err_n = 1'b1;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .clr    (clr),
    .go     (go),
    .is_div (opcode == OP_DIV),
    .a      (A),
    .b      (B),
    .busy   (busy),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .fin    (fin)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      done   <= 1'b0;
      C      <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      err    <= 1'b0;
      md_div <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        md_div <= (opcode == OP_DIV);
      end
      if (fin) begin
        done  <= 1'b1;
        C     <= {res_hi, res_lo};
        zero  <= md_div ? (res_lo == '0) : ({res_hi, res_lo} == '0);
        neg   <= md_div ? res_lo[WIDTH-1] : res_hi[WIDTH-1];
        carry <= 1'b0;
        ovf   <= 1'b0;
        dz    <= 1'b0;
        err   <= 1'b0;
      end else if (accept && !is_md) begin
        done  <= 1'b1;
        C     <= {hi_n, lo_n};
        zero  <= (lo_n == '0);
        neg   <= lo_n[WIDTH-1];
        carry <= carry_n;
        ovf   <= ovf_n;
        dz    <= dz_n;
        err   <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32 and WIDTH=16 driven with identical stimulus.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic        busy32, done32, zero32, neg32, carry32, ovf32, dz32, err32;
  logic [63:0] c32;
  logic        busy16, done16, zero16, neg16, carry16, ovf16, dz16, err16;
  logic [31:0] c16;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode), .A(a_in), .B(b_in),
    .busy(busy32), .done(done32), .C(c32), .zero(zero32), .neg(neg32),
    .carry(carry32), .ovf(ovf32), .dz(dz32), .err(err32)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode), .A(a_in[15:0]), .B(b_in[15:0]),
    .busy(busy16), .done(done16), .C(c16), .zero(zero16), .neg(neg16),
    .carry(carry16), .ovf(ovf16), .dz(dz16), .err(err16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers, then truncated to the DUT width.
  function automatic void model(input int w, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] c,
                                output logic [5:0] fl, output bit multi);
    logic [63:0] mask, ua, ub, lo, hi;
    longint      sa, sb, s, q, r, vmax, vmin;
    int          sh;
    bit          z, n, cy, ov, dzv, er;
    mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    sa   = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
    sb   = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
    sh   = int'(ub) & (w - 1);
    vmax = (longint'(1) << (w - 1)) - 1;
    vmin = -(longint'(1) << (w - 1));
    lo = 0; hi = 0; cy = 0; ov = 0; dzv = 0; er = 0; multi = 0;
    case (op)
      5'd1: begin s = sa + sb; lo = (ua + ub) & mask; cy = ((ua + ub) >> w) != 0;
                  ov = (s > vmax) || (s < vmin); end
      5'd2: begin s = sa - sb; lo = (ua - ub) & mask; cy = (ua >= ub);
                  ov = (s > vmax) || (s < vmin); end
      5'd3: begin multi = 1; s = sa * sb; lo = s & mask; hi = (s >>> w) & mask; end
      5'd4: begin
        if (ub == 0) begin lo = mask; hi = ua; dzv = 1; end
        else begin multi = 1; q = sa / sb; r = sa % sb; lo = q & mask; hi = r & mask; end
      end
      5'd5:  lo = ua >> sh;
      5'd6:  lo = (ua << sh) & mask;
      5'd7:  lo = (sa >>> sh) & mask;
      5'd8:  lo = ((ua >> sh) | (ua << (w - sh))) & mask;
      5'd9:  lo = ((ua << sh) | (ua >> (w - sh))) & mask;
      5'd10: lo = ua & ub;
      5'd11: lo = ua | ub;
      5'd12: lo = (-sa) & mask;
      5'd13: lo = ~ua & mask;
      default: er = 1;
    endcase
    c  = (hi << w) | lo;
    z  = (op == 5'd3) ? (c == 0) : (lo == 0);
    n  = (op == 5'd3) ? c[2*w-1] : lo[w-1];
    fl = {z, n, cy, ov, dzv, er};
  endfunction

  // Model state per instance: index 0 is WIDTH=32, index 1 is WIDTH=16.
  int          pend[2];
  logic [63:0] pend_c[2], exp_c[2];
  logic [5:0]  pend_fl[2], exp_fl[2];
  bit          exp_done[2];

  initial begin
    logic [63:0] mc, act_c;
    logic [5:0]  mfl, act_fl;
    bit          mm, act_done, act_busy;
    int          w;
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; exp_c[d] = 0; exp_fl[d] = 0; exp_done[d] = 0;
    end
    forever begin
      @(posedge clk);
      if (clr) begin
        for (int d = 0; d < 2; d++) begin
          w = (d == 0) ? 32 : 16;
          exp_done[d] = 0;
          if (pend[d] > 0) begin
            pend[d]--;
            if (pend[d] == 0) begin
              exp_done[d] = 1; exp_c[d] = pend_c[d]; exp_fl[d] = pend_fl[d];
            end
          end else if (start) begin
            model(w, opcode, a_in, b_in, mc, mfl, mm);
            if (mm) begin
              pend[d] = w + 1; pend_c[d] = mc; pend_fl[d] = mfl;
            end else begin
              exp_done[d] = 1; exp_c[d] = mc; exp_fl[d] = mfl;
            end
          end
        end
      end
      @(negedge clk);
      if (!clr) begin
        for (int d = 0; d < 2; d++) begin
          pend[d] = 0; exp_c[d] = 0; exp_fl[d] = 0; exp_done[d] = 0;
        end
      end
      for (int d = 0; d < 2; d++) begin
        act_c    = (d == 0) ? c32 : {32'h0, c16};
        act_fl   = (d == 0) ? {zero32, neg32, carry32, ovf32, dz32, err32}
                            : {zero16, neg16, carry16, ovf16, dz16, err16};
        act_done = (d == 0) ? done32 : done16;
        act_busy = (d == 0) ? busy32 : busy16;
        chk((d == 0) ? "done32" : "done16", 64'(act_done), 64'(exp_done[d]));
        chk((d == 0) ? "busy32" : "busy16", 64'(act_busy), 64'(pend[d] > 0));
        chk((d == 0) ? "c32" : "c16", act_c, exp_c[d]);
        chk((d == 0) ? "flags32" : "flags16", 64'(act_fl), 64'(exp_fl[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int          lat[2];
  logic [63:0] got_c[2];
  logic [5:0]  got_fl[2];

  // Issues one op, then waits (bounded) until both instances have pulsed done.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    bit seen[2];
    int k;
    start = 1; opcode = op; a_in = a; b_in = b;
    step();
    k = 0; seen[0] = 0; seen[1] = 0; lat[0] = -1; lat[1] = -1;
    while (k <= 60) begin
      if (done32 && !seen[0]) begin
        seen[0] = 1; lat[0] = k; got_c[0] = c32;
        got_fl[0] = {zero32, neg32, carry32, ovf32, dz32, err32};
      end
      if (done16 && !seen[1]) begin
        seen[1] = 1; lat[1] = k; got_c[1] = {32'h0, c16};
        got_fl[1] = {zero16, neg16, carry16, ovf16, dz16, err16};
      end
      if (seen[0] && seen[1]) break;
      start  = poke && (k == 4);
      opcode = 5'd1;
      a_in   = $urandom;
      b_in   = $urandom;
      step();
      k++;
    end
    start = 0;
    chk("done_seen32", 64'(seen[0]), 64'd1);
    chk("done_seen16", 64'(seen[1]), 64'd1);
  endtask

  function automatic logic [31:0] rnd_opd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_8000;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] mc;
    logic [5:0]  mfl;
    bit          mm;
    logic [4:0]  rop;
    int          r;

    model(32, 5'd1, 32'd10, 32'd20, mc, mfl, mm);
    chk("model_add", mc, 64'd30);
    model(32, 5'd3, 32'hFFFF_FFF9, 32'd6, mc, mfl, mm);
    chk("model_mul", mc, 64'hFFFF_FFFF_FFFF_FFD6);
    model(16, 5'd4, 32'hFFFF_FF9C, 32'd7, mc, mfl, mm);
    chk("model_div16", mc, 64'hFFFE_FFF2);
    model(32, 5'd9, 32'h8000_0001, 32'd1, mc, mfl, mm);
    chk("model_rol", mc, 64'd3);

    clr = 0; start = 0; opcode = 0; a_in = 0; b_in = 0;
    step();
    chk("rst_c32", c32, 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    step(); step();
    clr = 1;
    step();

    run_op(5'd1, 32'd10, 32'd20, 0);
    chk("add_lat", 64'(lat[0]), 64'd0);
    chk("add_c", got_c[0], 64'd30);
    chk("add_fl", 64'(got_fl[0]), 64'b000000);
    run_op(5'd1, 32'h7FFF_FFFF, 32'd1, 0);
    chk("addovf_c", got_c[0], 64'h8000_0000);
    chk("addovf_fl", 64'(got_fl[0]), 64'b010100);
    run_op(5'd7, 32'hFFFF_FFF6, 32'd2, 0);
    chk("shra_c", got_c[0], 64'hFFFF_FFFD);
    run_op(5'd8, 32'h5555_5555, 32'd4, 0);
    chk("ror_c", got_c[0], 64'h5555_5555);
    run_op(5'd6, 32'd10, 32'd36, 0);
    chk("shl_c", got_c[0], 64'd160);

    run_op(5'd3, 32'hFFFF_FFF9, 32'd6, 1);
    chk("mul_lat32", 64'(lat[0]), 64'd33);
    chk("mul_c32", got_c[0], 64'hFFFF_FFFF_FFFF_FFD6);
    chk("mul_fl32", 64'(got_fl[0]), 64'b010000);
    chk("mul_lat16", 64'(lat[1]), 64'd17);
    chk("mul_c16", got_c[1], 64'hFFFF_FFD6);

    run_op(5'd4, 32'hFFFF_FF9C, 32'd7, 0);
    chk("div_lat32", 64'(lat[0]), 64'd33);
    chk("div_c32", got_c[0], 64'hFFFF_FFFE_FFFF_FFF2);
    chk("div_lat16", 64'(lat[1]), 64'd17);
    chk("div_c16", got_c[1], 64'hFFFE_FFF2);

    run_op(5'd4, 32'd100, 32'd0, 0);
    chk("dz_lat", 64'(lat[0]), 64'd0);
    chk("dz_c32", got_c[0], 64'h0000_0064_FFFF_FFFF);
    chk("dz_fl32", 64'(got_fl[0]), 64'b010010);
    chk("dz_c16", got_c[1], 64'h0064_FFFF);

    run_op(5'd31, 32'd5, 32'd6, 0);
    chk("ill_c", got_c[0], 64'd0);
    chk("ill_err", 64'(got_fl[0][0]), 64'd1);
    run_op(5'd10, 32'h0000_00F0, 32'h0000_003C, 0);
    chk("and_c", got_c[0], 64'h30);
    chk("and_fl", 64'(got_fl[0]), 64'b000000);

    run_op(5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("minm1_c", got_c[0], 64'h0000_0000_8000_0000);
    chk("minm1_fl", 64'(got_fl[0]), 64'b010000);

    // Abandon a multiply mid-flight with an asynchronous reset.
    start = 1; opcode = 5'd3; a_in = 32'd1234; b_in = 32'd5678;
    step();
    start = 0;
    repeat (10) step();
    clr = 0;
    #1;
    chk("arst_busy32", 64'(busy32), 64'd0);
    chk("arst_busy16", 64'(busy16), 64'd0);
    chk("arst_c32", c32, 64'd0);
    chk("arst_fl32", 64'({zero32, neg32, carry32, ovf32, dz32, err32}), 64'd0);
    step(); step();
    clr = 1;
    step();
    run_op(5'd1, 32'd1, 32'd1, 0);
    chk("post_rst_add", got_c[0], 64'd2);

    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        clr = 0; step(); step(); clr = 1;
      end
      r = $urandom_range(0, 19);
      if (r < 13)       rop = 5'(r + 1);
      else if (r == 13) rop = 5'd0;
      else              rop = 5'($urandom_range(14, 31));
      if ($urandom_range(0, 2) == 0) rop = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'd4;
      start  = ($urandom_range(0, 3) != 0);
      opcode = rop;
      a_in   = rnd_opd();
      b_in   = rnd_opd();
      step();
    end
    start = 0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
